// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller: turns EX/MEM load/store requests into a
// registered request/acknowledge transaction, stalling the pipeline until it completes.
module dmem_access_ctrl #(
  parameter int DSIZE   = 16,
  parameter int ASIZE   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  input  logic [ASIZE-1:0] addr_in,
  input  logic [DSIZE-1:0] wdata_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             stall,
  output logic [DSIZE-1:0] rdata_out,
  output logic             rdata_valid,
  output logic             err,
  output logic [15:0]      stall_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: mem_req rises on ACCESS entry and stays high, with mem_we/mem_addr/
  // mem_wdata frozen, until a cycle with mem_ack=1 (or timeout); mem_ack is only
  // sampled while mem_req=1 and a single ack cycle completes the transfer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t     state_q;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       illegal_q;
  logic       req_any;
  logic       start;
  logic       finish_ack;
  logic       finish_to;

  assign req_any   = memRead_in | memWrite_in;
  assign state_dbg = state_q;

  always_comb begin
    state_nxt  = state_q;
    stall      = 1'b0;
    start      = 1'b0;
    finish_ack = 1'b0;
    finish_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_nxt = ACCESS;
          stall     = 1'b1;
          start     = 1'b1;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack) begin
          finish_ack = 1'b1;
          state_nxt  = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          finish_to = 1'b1;
          state_nxt = DONE;
        end
      end
      // The instruction advances in DONE; any request still visible is the same one.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      wait_cnt    <= 4'd0;
      illegal_q   <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= memWrite_in;
        mem_addr  <= addr_in;
        mem_wdata <= wdata_in;
        wait_cnt  <= 4'd0;
        // Load and store together is malformed: the store goes out, the error is flagged.
        illegal_q <= memRead_in & memWrite_in;
      end
      if (state_q == ACCESS && !finish_ack && !finish_to) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (finish_ack) begin
        mem_req <= 1'b0;
        err     <= illegal_q;
        if (!mem_we) begin
          rdata_out   <= mem_rdata;
          rdata_valid <= 1'b1;
        end
      end
      if (finish_to) begin
        mem_req   <= 1'b0;
        rdata_out <= '0;
        err       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a table of load/store transactions plus
// hand-written back-to-back, reset-in-ACCESS and idle-ack sequences.
module tb_dmem_access_ctrl;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic        err;
  logic [15:0] stall_cnt;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;

  dmem_access_ctrl #(.DSIZE(16), .ASIZE(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .memRead_in(mem_read), .memWrite_in(mem_write),
    .addr_in(addr), .wdata_in(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .err(err), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ack_at;     // ACCESS cycle carrying mem_ack, 0 = never
    logic [15:0] rdata;
    logic        exp_we;
    int          exp_req;
    int          exp_stall;
    logic [15:0] exp_rdata;
    logic        exp_valid;
    logic        exp_err;
    int          exp_cnt;    // cumulative stall_cnt after this transaction
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   req_n;
    int   stall_n;
    logic hold_bad;
    logic early;
    logic seen_done;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; addr = v.addr; wdata = v.wdata; mem_ack = 1'b0;
    #1;
    check($sformatf("v%0d_idle_stall", idx), stall, 1);
    stall_n = int'(stall);
    req_n = 0; hold_bad = 1'b0; early = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      // ack stays high past completion so DONE also sees a stray ack with junk data
      mem_ack   = (v.ack_at != 0) && (c + 1 >= v.ack_at);
      mem_rdata = (c + 1 == v.ack_at) ? v.rdata : 16'hDEAD;
      #1;
      if (state_dbg == S_DONE) begin
        seen_done = 1'b1;
        break;
      end
      if (mem_req) req_n++;
      if (stall) stall_n++;
      if (mem_we !== v.exp_we || mem_addr !== v.addr || mem_wdata !== v.wdata) hold_bad = 1'b1;
      if (rdata_valid || err) early = 1'b1;
    end
    check($sformatf("v%0d_done_seen", idx), seen_done, 1);
    check($sformatf("v%0d_req_cycles", idx), req_n, v.exp_req);
    check($sformatf("v%0d_stall_cycles", idx), stall_n, v.exp_stall);
    check($sformatf("v%0d_hold_stable", idx), hold_bad, 0);
    check($sformatf("v%0d_no_early_pulse", idx), early, 0);
    check($sformatf("v%0d_done_stall", idx), stall, 0);
    check($sformatf("v%0d_done_req", idx), mem_req, 0);
    check($sformatf("v%0d_rdata", idx), rdata_out, v.exp_rdata);
    check($sformatf("v%0d_valid", idx), rdata_valid, v.exp_valid);
    check($sformatf("v%0d_err", idx), err, v.exp_err);
    check($sformatf("v%0d_stall_cnt", idx), stall_cnt, v.exp_cnt);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check($sformatf("v%0d_back_idle", idx), state_dbg, S_IDLE);
    check($sformatf("v%0d_idle_stall0", idx), stall, 0);
    check($sformatf("v%0d_rdata_kept", idx), rdata_out, v.exp_rdata);
    check($sformatf("v%0d_pulses_gone", idx), {rdata_valid, err}, 0);
    mem_ack = 1'b0;
  endtask

  initial begin
    //          rd    wr    addr      wdata     ack rdata     we    req st rdata_exp  vld   err   cnt
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0, 1, 2, 16'hBEEF, 1'b1, 1'b0, 2};
    vecs[1] = '{1'b0, 1'b1, 16'h0004, 16'h1234, 3, 16'h5555, 1'b1, 3, 4, 16'hBEEF, 1'b0, 1'b0, 6};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 0, 16'h0000, 1'b0, 8, 9, 16'h0000, 1'b0, 1'b1, 15};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 5, 16'hCAFE, 1'b0, 5, 6, 16'hCAFE, 1'b1, 1'b0, 21};
    vecs[4] = '{1'b1, 1'b1, 16'h0030, 16'h5A5A, 2, 16'h1111, 1'b1, 2, 3, 16'hCAFE, 1'b0, 1'b1, 24};
    vecs[5] = '{1'b0, 1'b1, 16'h0008, 16'h7777, 0, 16'h0000, 1'b1, 8, 9, 16'h0000, 1'b0, 1'b1, 33};
    vecs[6] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 8, 16'h0042, 1'b0, 8, 9, 16'h0042, 1'b1, 1'b0, 42};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", state_dbg, S_IDLE);
    check("reset_outputs", {mem_req, mem_we, rdata_valid, err, stall}, 0);
    check("reset_regs", {mem_addr, mem_wdata, rdata_out}, 0);
    check("reset_stall_cnt", stall_cnt, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // back-to-back loads, the second requested right after DONE
    @(negedge clk);
    mem_read = 1'b1; addr = 16'h0100;
    #1;
    check("b2b_first_stall", stall, 1);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h0A0A;
    #1;
    check("b2b_first_access", state_dbg, S_ACCESS);
    @(negedge clk);
    mem_rdata = 16'hDEAD;
    #1;
    check("b2b_first_done", state_dbg, S_DONE);
    check("b2b_first_rdata", rdata_out, 16'h0A0A);
    check("b2b_done_stall", stall, 0);
    @(negedge clk);
    mem_ack = 1'b0; addr = 16'h0200;
    #1;
    check("b2b_idle", state_dbg, S_IDLE);
    check("b2b_stray_ack_ignored", {rdata_valid, rdata_out}, {1'b0, 16'h0A0A});
    check("b2b_second_stall", stall, 1);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h0B0B;
    #1;
    check("b2b_second_access", state_dbg, S_ACCESS);
    check("b2b_second_addr", mem_addr, 16'h0200);
    check("b2b_second_req", mem_req, 1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("b2b_second_done", state_dbg, S_DONE);
    check("b2b_second_rdata", {rdata_valid, rdata_out}, {1'b1, 16'h0B0B});
    check("b2b_stall_cnt", stall_cnt, 46);
    @(negedge clk);
    mem_read = 1'b0;
    #1;

    // reset on the second ACCESS cycle
    @(negedge clk);
    mem_read = 1'b1; addr = 16'h0300;
    @(negedge clk);
    #1;
    check("rst_seq_access1", state_dbg, S_ACCESS);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_seq_access2", {state_dbg, mem_req}, {S_ACCESS, 1'b1});
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    #1;
    check("rst_seq_state", state_dbg, S_IDLE);
    check("rst_seq_req", mem_req, 0);
    check("rst_seq_stall_cnt", stall_cnt, 0);
    check("rst_seq_pulses", {rdata_valid, err}, 0);
    check("rst_seq_rdata", rdata_out, 0);

    // ack while idle must not disturb anything
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    @(negedge clk);
    #1;
    check("idle_ack_state", state_dbg, S_IDLE);
    check("idle_ack_rdata", {rdata_valid, rdata_out}, 0);
    check("idle_ack_req", {mem_req, stall}, 0);
    mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
